frogger_anim_sequencer: RTL and testbench

//  Downstream consumer of the free-running animation speed counter (COUNT_WIDTH-bit up-counter, active-low clear, active-low count enable).

---
 rtl/frogger_anim_sequencer.sv | 148 ++++++++++++++
 tb/tb_frogger_anim_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_anim_sequencer.sv
// frogger_anim_sequencer
//   Closes the loop around the free-running animation speed counter. It
//   watches the counter value, detects the terminal count for the selected
//   speed, clears the counter, and on each terminal count advances a sprite
//   frame index and emits a one-cycle step pulse (plus a wrap pulse when the
//   frame index rolls over).
//
// Ports
//   SC_ANIMSEQ_CLOCK_50        in  system clock (50 MHz)
//   SC_ANIMSEQ_RESET_InLow     in  synchronous reset, active low
//   SC_ANIMSEQ_count_InBUS     in  current counter value
//   SC_ANIMSEQ_enable_In       in  1 = animate, 0 = idle with counter cleared
//   SC_ANIMSEQ_pause_In        in  1 = freeze counter and frame
//   SC_ANIMSEQ_dir_In          in  0 = frame increments, 1 = frame decrements
//   SC_ANIMSEQ_speed_InBUS     in  speed select, limit = LIMIT_BASE >> speed
//   SC_ANIMSEQ_clear_OutLow    out counter clear, 0 = clear on next edge
//   SC_ANIMSEQ_upcount_OutLow  out counter count-enable, 0 = count
//   SC_ANIMSEQ_frame_OutBUS    out current frame index
//   SC_ANIMSEQ_step_Out        out one-cycle pulse per frame advance
//   SC_ANIMSEQ_wrap_Out        out one-cycle pulse when the frame wraps
module frogger_anim_sequencer #(
  parameter int COUNT_WIDTH = 24,
  parameter int FRAME_WIDTH = 3,
  parameter int NUM_FRAMES  = 8,
  parameter int LIMIT_BASE  = 12_500_000
) (
  input  logic                   SC_ANIMSEQ_CLOCK_50,
  input  logic                   SC_ANIMSEQ_RESET_InLow,
  input  logic [COUNT_WIDTH-1:0] SC_ANIMSEQ_count_InBUS,
  input  logic                   SC_ANIMSEQ_enable_In,
  input  logic                   SC_ANIMSEQ_pause_In,
  input  logic                   SC_ANIMSEQ_dir_In,
  input  logic [1:0]             SC_ANIMSEQ_speed_InBUS,
  output logic                   SC_ANIMSEQ_clear_OutLow,
  output logic                   SC_ANIMSEQ_upcount_OutLow,
  output logic [FRAME_WIDTH-1:0] SC_ANIMSEQ_frame_OutBUS,
  output logic                   SC_ANIMSEQ_step_Out,
  output logic                   SC_ANIMSEQ_wrap_Out
);

  // Compare width: wide enough for both the counter and the 32-bit base,
  // plus one spare bit so limit-1 never underflows into a false match.
  localparam int CMP_W = (COUNT_WIDTH > 32) ? COUNT_WIDTH + 1 : 33;
  localparam logic [CMP_W-1:0] BASE = CMP_W'(LIMIT_BASE);
  localparam logic [FRAME_WIDTH-1:0] LAST_FRAME = FRAME_WIDTH'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    PAUSED = 2'd3
  } stateT;

  stateT                  state;
  stateT                  stateNext;
  logic [FRAME_WIDTH-1:0] frame;
  logic [FRAME_WIDTH-1:0] frameNext;
  logic                   wrapReg;
  logic                   wrapNext;
  logic [CMP_W-1:0]       limitVal;
  logic [CMP_W-1:0]       countExt;
  logic                   terminal;
  logic [FRAME_WIDTH:0]   advanced;

  // Terminal limit for a speed setting; a base that shifts down to zero is
  // clamped to 1 so the fastest setting still produces a step every 2 clocks.
  function automatic logic [CMP_W-1:0] limitFor(input logic [1:0] speed);
    logic [CMP_W-1:0] lim;
    lim = BASE >> speed;
    if (lim == '0) lim = CMP_W'(1);
    return lim;
  endfunction

  // Next frame index with the wrap flag in the MSB.
  function automatic logic [FRAME_WIDTH:0] advanceFrame(
    input logic [FRAME_WIDTH-1:0] cur,
    input logic                   dir
  );
    logic [FRAME_WIDTH:0] res;
    if (!dir) begin
      if (cur == LAST_FRAME) res = {1'b1, {FRAME_WIDTH{1'b0}}};
      else                   res = {1'b0, cur + 1'b1};
    end else begin
      if (cur == '0) res = {1'b1, LAST_FRAME};
      else           res = {1'b0, cur - 1'b1};
    end
    return res;
  endfunction

  // Limit is recomputed every cycle; >= lets a lowered limit take effect on
  // the very next compare even if the counter is already past it.
  assign limitVal = limitFor(SC_ANIMSEQ_speed_InBUS);
  assign countExt = {{(CMP_W - COUNT_WIDTH){1'b0}}, SC_ANIMSEQ_count_InBUS};
  assign terminal = (countExt >= (limitVal - CMP_W'(1)));
  assign advanced = advanceFrame(frame, SC_ANIMSEQ_dir_In);

  always_ff @(posedge SC_ANIMSEQ_CLOCK_50) begin
    if (!SC_ANIMSEQ_RESET_InLow) begin
      state   <= IDLE;
      frame   <= '0;
      wrapReg <= 1'b0;
    end else begin
      state   <= stateNext;
      frame   <= frameNext;
      wrapReg <= wrapNext;
    end
  end

  // Priority within each state: enable=0 > pause > terminal.
  always_comb begin
    stateNext = state;
    frameNext = frame;
    wrapNext  = 1'b0;
    case (state)
      IDLE: begin
        if (SC_ANIMSEQ_enable_In) stateNext = RUN;
      end
      RUN: begin
        if (!SC_ANIMSEQ_enable_In)    stateNext = IDLE;
        else if (SC_ANIMSEQ_pause_In) stateNext = PAUSED;
        else if (terminal) begin
          stateNext = STEP;
          frameNext = advanced[FRAME_WIDTH-1:0];
          wrapNext  = advanced[FRAME_WIDTH];
        end
      end
      STEP: begin
        if (!SC_ANIMSEQ_enable_In)    stateNext = IDLE;
        else if (SC_ANIMSEQ_pause_In) stateNext = PAUSED;
        else                          stateNext = RUN;
      end
      PAUSED: begin
        if (!SC_ANIMSEQ_enable_In)     stateNext = IDLE;
        else if (!SC_ANIMSEQ_pause_In) stateNext = RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Moore outputs decoded from state. PAUSED keeps clear and count-enable
  // both inactive so the counter simply holds its value.
  assign SC_ANIMSEQ_clear_OutLow   = (state == RUN) || (state == PAUSED);
  assign SC_ANIMSEQ_upcount_OutLow = (state != RUN);
  assign SC_ANIMSEQ_step_Out       = (state == STEP);
  assign SC_ANIMSEQ_wrap_Out       = wrapReg;
  assign SC_ANIMSEQ_frame_OutBUS   = frame;

endmodule

// File: tb/tb_frogger_anim_sequencer.sv
module tb_frogger_anim_sequencer;

  localparam int CW    = 24;
  localparam int FW    = 3;
  localparam int NF    = 8;
  localparam int LBASE = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CW-1:0] cnt = '0;
  logic          en;
  logic          pause;
  logic          dir;
  logic [1:0]    speed;
  logic          clearN;
  logic          upN;
  logic [FW-1:0] frame;
  logic          step;
  logic          wrap;

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 running, 2 stepping, 3 paused.
  int mState = 0;
  int mFrame = 0;
  int mWrap  = 0;

  int nSteps;
  int nWraps;
  int lastStep;
  int reached;

  always #10 clk = ~clk;

  frogger_anim_sequencer #(
    .COUNT_WIDTH(CW),
    .FRAME_WIDTH(FW),
    .NUM_FRAMES (NF),
    .LIMIT_BASE (LBASE)
  ) dut (
    .SC_ANIMSEQ_CLOCK_50      (clk),
    .SC_ANIMSEQ_RESET_InLow   (rstn),
    .SC_ANIMSEQ_count_InBUS   (cnt),
    .SC_ANIMSEQ_enable_In     (en),
    .SC_ANIMSEQ_pause_In      (pause),
    .SC_ANIMSEQ_dir_In        (dir),
    .SC_ANIMSEQ_speed_InBUS   (speed),
    .SC_ANIMSEQ_clear_OutLow  (clearN),
    .SC_ANIMSEQ_upcount_OutLow(upN),
    .SC_ANIMSEQ_frame_OutBUS  (frame),
    .SC_ANIMSEQ_step_Out      (step),
    .SC_ANIMSEQ_wrap_Out      (wrap)
  );

  // Speed counter in the loop: active-low clear, active-low count enable.
  always @(posedge clk) begin
    if (clearN === 1'b0)   cnt <= '0;
    else if (upN === 1'b0) cnt <= cnt + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs();
    check("clear_OutLow", {31'd0, clearN}, ((mState == 1) || (mState == 3)) ? 32'd1 : 32'd0);
    check("upcount_OutLow", {31'd0, upN}, (mState == 1) ? 32'd0 : 32'd1);
    check("step", {31'd0, step}, (mState == 2) ? 32'd1 : 32'd0);
    check("wrap", {31'd0, wrap}, 32'(mWrap));
    check("frame", {29'd0, frame}, 32'(mFrame));
  endtask

  // Advance one clock: model consumes the inputs and counter value present
  // before the edge, then outputs are compared 1 time unit after the edge.
  task automatic cycle();
    int lim;
    int nS;
    int nF;
    int nW;
    lim = LBASE >> speed;
    if (lim < 1) lim = 1;
    nS = mState;
    nF = mFrame;
    nW = 0;
    if (!rstn) begin
      nS = 0;
      nF = 0;
    end else begin
      case (mState)
        0: if (en) nS = 1;
        1: begin
          if (!en) nS = 0;
          else if (pause) nS = 3;
          else if (int'(cnt) >= lim - 1) begin
            nS = 2;
            if (!dir) begin
              nW = (mFrame == NF - 1) ? 1 : 0;
              nF = (mFrame + 1) % NF;
            end else begin
              nW = (mFrame == 0) ? 1 : 0;
              nF = (mFrame + NF - 1) % NF;
            end
          end
        end
        2: begin
          if (!en) nS = 0;
          else if (pause) nS = 3;
          else nS = 1;
        end
        default: begin
          if (!en) nS = 0;
          else if (!pause) nS = 1;
        end
      endcase
    end
    @(posedge clk);
    #1;
    mState = nS;
    mFrame = nF;
    mWrap  = nW;
    checkOutputs();
  endtask

  initial begin
    rstn  = 1'b0;
    en    = 1'b0;
    pause = 1'b0;
    dir   = 1'b0;
    speed = 2'd0;

    // Reset held for 3 clocks.
    for (int i = 0; i < 3; i++) cycle();
    check("reset_frame", {29'd0, frame}, 32'd0);
    check("reset_clear", {31'd0, clearN}, 32'd0);
    check("reset_upcount", {31'd0, upN}, 32'd1);

    // Speed 0 (L=4): step every 5 clocks, 8 steps bring the frame back to 0.
    rstn = 1'b1;
    en   = 1'b1;
    nSteps = 0;
    nWraps = 0;
    lastStep = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (step === 1'b1) begin
        if (lastStep >= 0) check("step_period_L4", 32'(i - lastStep), 32'd5);
        check("frame_seq", {29'd0, frame}, 32'((nSteps + 1) % NF));
        check("wrap_only_7to0", {31'd0, wrap}, (nSteps == NF - 1) ? 32'd1 : 32'd0);
        lastStep = i;
        nSteps++;
        if (wrap === 1'b1) nWraps++;
      end
    end
    check("steps_in_40", 32'(nSteps), 32'd8);
    check("wraps_in_40", 32'(nWraps), 32'd1);
    check("frame_after_cycle", {29'd0, frame}, 32'd0);

    // Speed 2 (L=1): step every 2 clocks.
    speed  = 2'd2;
    nSteps = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (step === 1'b1) nSteps++;
    end
    check("steps_L1_in_10", 32'(nSteps), 32'd5);

    // Lowering the limit while the count is already past it forces a step.
    speed = 2'd0;
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      if (mState == 1 && cnt == 1) reached = 1;
      else cycle();
    end
    check("reach_speed_switch", 32'(reached), 32'd1);
    speed = 2'd2;
    cycle();
    check("speed_switch_step", {31'd0, step}, 32'd1);
    speed = 2'd0;

    // Pause lands with the counter at 2 and holds it there.
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      if (mState == 1 && cnt == 1) reached = 1;
      else cycle();
    end
    check("reach_pause", 32'(reached), 32'd1);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("pause_count_hold", 32'(cnt), 32'd2);
      check("pause_no_step", {31'd0, step}, 32'd0);
    end
    pause = 1'b0;
    reached = 0;
    for (int i = 0; i < 6 && reached == 0; i++) begin
      cycle();
      if (step === 1'b1) reached = 1;
    end
    check("step_after_release", 32'(reached), 32'd1);

    // Reverse direction from frame 0: first step wraps to the last frame.
    rstn = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
    dir  = 1'b1;
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      cycle();
      if (step === 1'b1) reached = 1;
    end
    check("reach_dir_step", 32'(reached), 32'd1);
    check("dir1_frame", {29'd0, frame}, 32'(NF - 1));
    check("dir1_wrap", {31'd0, wrap}, 32'd1);

    // Reset mid-run at frame 5.
    dir = 1'b0;
    reached = 0;
    for (int i = 0; i < 120 && reached == 0; i++) begin
      if (mState == 1 && mFrame == 5) reached = 1;
      else cycle();
    end
    check("reach_frame5", 32'(reached), 32'd1);
    check("frame5_before_reset", {29'd0, frame}, 32'd5);
    rstn = 1'b0;
    cycle();
    check("midrun_reset_frame", {29'd0, frame}, 32'd0);
    check("midrun_reset_clear", {31'd0, clearN}, 32'd0);
    check("midrun_reset_step", {31'd0, step}, 32'd0);
    rstn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      en    = ($urandom_range(0, 29) != 0);
      pause = ($urandom_range(0, 11) == 0);
      rstn  = ($urandom_range(0, 149) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
